// File: rtl/timer_pkg.sv
// timer_pkg: bus modes, register offsets and CTRL field positions shared by the timer files.
package timer_pkg;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_COMPARE = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AR      = 1;
    localparam int CTRL_PSC_LSB = 8;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer with prescaler, compare match, auto-reload/one-shot and sticky pending flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_count,
    input  logic        i_wr_compare,
    input  logic        i_wr_status,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_roff,
    output logic [31:0] o_rdata,
    output logic        o_irq_n
);
    logic                      r_en;
    logic                      r_ar;
    logic [PRESCALE_WIDTH-1:0] r_psc;
    logic [PRESCALE_WIDTH-1:0] r_pre;
    logic [31:0]               r_count;
    logic [31:0]               r_compare;
    logic                      r_pend;
    logic                      w_tick;
    logic                      w_eq;
    logic                      w_match;
    logic [31:0]               w_ctrl;

    assign w_tick  = r_en && (r_pre == r_psc);
    assign w_eq    = r_count == r_compare;
    // a bus write to COUNT on a tick edge overrides the whole count/match evaluation
    assign w_match = w_tick && w_eq && !i_wr_count;
    assign w_ctrl  = (32'(r_psc) << CTRL_PSC_LSB) | (32'(r_ar) << CTRL_AR) | (32'(r_en) << CTRL_EN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en      <= 1'b0;
            r_ar      <= 1'b0;
            r_psc     <= '0;
            r_pre     <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_pre   <= i_wr_ctrl ? '0 : !r_en ? r_pre : w_tick ? '0 : r_pre + 1'b1;
            r_en    <= i_wr_ctrl ? i_wdata[CTRL_EN] : (w_match && !r_ar) ? 1'b0 : r_en;
            r_count <= i_wr_count ? i_wdata : !w_tick ? r_count : !w_eq ? r_count + 32'd1 : r_ar ? '0 : r_count;
            if (i_wr_ctrl) begin
                r_ar  <= i_wdata[CTRL_AR];
                r_psc <= i_wdata[CTRL_PSC_LSB +: PRESCALE_WIDTH];
            end
            if (i_wr_compare)
                r_compare <= i_wdata;
            // set dominates a same-cycle clear
            r_pend <= w_match || (r_pend && !(i_wr_status && i_wdata[0]));
        end
    end

    assign o_rdata = (i_roff == OFF_CTRL)    ? w_ctrl :
                     (i_roff == OFF_COUNT)   ? r_count :
                     (i_roff == OFF_COMPARE) ? r_compare :
                     (i_roff == OFF_STATUS)  ? {31'b0, r_pend} : '0;
    assign o_irq_n = ~r_pend;
endmodule

// File: rtl/timer_unit.sv
// timer_unit: dual 32-bit timer peripheral; decodes the shared bus and drives read data only on a hit.
module timer_unit
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h4020,
    parameter int          PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] data_bus_data,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    output logic [1:0]  irq_tim_n
);
    logic [31:0] w_off;
    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_rdata [2];

    assign w_off = data_bus_addr - BASE_ADDR;
    assign w_hit = (w_off[31:5] == '0) && (w_off[1:0] == 2'b00);
    assign w_wr  = w_hit && (data_bus_mode == MODE_WRITE);
    assign w_rd  = w_hit && (data_bus_mode == MODE_READ);

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic w_sel;
        assign w_sel = w_wr && (w_off[4] == 1'(c));
        timer_channel #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .i_wr_ctrl    (w_sel && (w_off[3:0] == OFF_CTRL)),
            .i_wr_count   (w_sel && (w_off[3:0] == OFF_COUNT)),
            .i_wr_compare (w_sel && (w_off[3:0] == OFF_COMPARE)),
            .i_wr_status  (w_sel && (w_off[3:0] == OFF_STATUS)),
            .i_wdata      (data_bus_data),
            .i_roff       (w_off[3:0]),
            .o_rdata      (w_rdata[c]),
            .o_irq_n      (irq_tim_n[c])
        );
    end

    assign data_bus_data = w_rd ? w_rdata[w_off[4]] : 'z;
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed checks of the dual timer against hand-computed cycle timelines.
module tb_timer_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  mode = 2'b00;
    logic [1:0]  irq;
    logic [31:0] drv = '0;
    logic        drv_en = 1'b0;
    tri1  [31:0] bus;
    int          n_vec = 0;
    int          n_err = 0;

    assign bus = drv_en ? drv : 'z;
    always #5 clk = ~clk;

    timer_unit dut (
        .clk           (clk),
        .reset         (reset),
        .data_bus_data (bus),
        .data_bus_addr (addr),
        .data_bus_mode (mode),
        .irq_tim_n     (irq)
    );

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; drv = d; drv_en = 1'b1; mode = 2'b10;
        @(posedge clk); #1;
        mode = 2'b00; drv_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; mode = 2'b01;
        #1 d = bus;
        mode = 2'b00;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clean(input logic [31:0] b);
        wr(b, 0); wr(b + 4, 0); wr(b + 8, 0); wr(b + 12, 1);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        step(2);
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL rst_irq_in_reset got %b exp 11", irq); end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(32'h4020 + 32'(i * 4), d);
            n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_reg%0d got %h exp 00000000", i, d); end
        end
        rd(32'h4000, d);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_highz got %h exp ffffffff", d); end
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL rst_irq got %b exp 11", irq); end
    endtask

    task automatic test_autoreload;
        logic [31:0] d;
        wr(32'h4028, 3);
        wr(32'h4020, 32'h003);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ar_count_e0 got %h exp 0", d); end
        for (int i = 1; i <= 3; i++) begin
            step(1);
            rd(32'h4024, d);
            n_vec++; if (d !== 32'(i)) begin n_err++; $display("FAIL ar_count_e%0d got %h exp %h", i, d, 32'(i)); end
        end
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL ar_irq_e3 got %b exp 11", irq); end
        step(1);
        rd(32'h4024, d);
        n_vec++; if (irq !== 2'b10) begin n_err++; $display("FAIL ar_irq_e4 got %b exp 10", irq); end
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ar_count_e4 got %h exp 0", d); end
        wr(32'h402C, 1);
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL ar_clear_e5 got %b exp 11", irq); end
        step(2);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'd3 || irq !== 2'b11) begin n_err++; $display("FAIL ar_e7 got count %h irq %b exp 3 11", d, irq); end
        step(1);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'd0 || irq !== 2'b10) begin n_err++; $display("FAIL ar_e8 got count %h irq %b exp 0 10", d, irq); end
        clean(32'h4020);
    endtask

    task automatic test_prescale;
        logic [31:0] d;
        wr(32'h4028, 1);
        wr(32'h4020, 32'h203);
        step(2);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL psc_count_e2 got %h exp 0", d); end
        step(1);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL psc_count_e3 got %h exp 1", d); end
        step(2);
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL psc_irq_e5 got %b exp 11", irq); end
        step(1);
        n_vec++; if (irq !== 2'b10) begin n_err++; $display("FAIL psc_irq_e6 got %b exp 10", irq); end
        rd(32'h402C, d);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL psc_status got %h exp 1", d); end
        wr(32'h402C, 1);
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL psc_clear_e7 got %b exp 11", irq); end
        clean(32'h4020);
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        wr(32'h4038, 2);
        wr(32'h4030, 32'h001);
        step(2);
        rd(32'h4034, d);
        n_vec++; if (d !== 32'd2 || irq !== 2'b11) begin n_err++; $display("FAIL os_e2 got count %h irq %b exp 2 11", d, irq); end
        step(1);
        n_vec++; if (irq !== 2'b01) begin n_err++; $display("FAIL os_irq_e3 got %b exp 01", irq); end
        rd(32'h4030, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL os_ctrl got %h exp 0", d); end
        step(5);
        rd(32'h4034, d);
        n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL os_count_hold got %h exp 2", d); end
        rd(32'h4024, d);
        n_vec++; if (d !== 32'd0 || irq !== 2'b01) begin n_err++; $display("FAIL os_tim1 got count %h irq %b exp 0 01", d, irq); end
        clean(32'h4030);
    endtask

    task automatic test_collisions;
        logic [31:0] d;
        wr(32'h4028, 1);
        wr(32'h4020, 32'h003);
        step(1);
        wr(32'h402C, 1);
        n_vec++; if (irq !== 2'b10) begin n_err++; $display("FAIL col_clr_first_match got %b exp 10", irq); end
        step(1);
        wr(32'h402C, 1);
        n_vec++; if (irq !== 2'b10) begin n_err++; $display("FAIL col_clr_second_match got %b exp 10", irq); end
        wr(32'h402C, 1);
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL col_clr_no_match got %b exp 11", irq); end
        clean(32'h4020);
        wr(32'h4028, 32'h100);
        wr(32'h4020, 32'h001);
        wr(32'h4024, 32'h10);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'h10) begin n_err++; $display("FAIL col_cnt_wr got %h exp 10", d); end
        step(1);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'h11) begin n_err++; $display("FAIL col_cnt_inc got %h exp 11", d); end
        wr(32'h4028, 32'h12);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'h12) begin n_err++; $display("FAIL col_cnt_e3 got %h exp 12", d); end
        wr(32'h4024, 32'h5);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'h5 || irq !== 2'b11) begin n_err++; $display("FAIL col_wr_beats_match got count %h irq %b exp 5 11", d, irq); end
        rd(32'h4020, d);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL col_en_kept got %h exp 1", d); end
        clean(32'h4020);
        wr(32'h4028, 5);
        wr(32'h4024, 32'hFFFF_FFFF);
        wr(32'h4020, 32'h001);
        step(1);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'd0 || irq !== 2'b11) begin n_err++; $display("FAIL col_wrap got count %h irq %b exp 0 11", d, irq); end
        step(1);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL col_wrap_next got %h exp 1", d); end
        clean(32'h4020);
    endtask

    task automatic test_decode;
        logic [31:0] d;
        wr(32'h4022, 32'hFFFF_FFFF);
        wr(32'h4040, 32'hFFFF_FFFF);
        rd(32'h4020, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL dec_ctrl_untouched got %h exp 0", d); end
        rd(32'h4030, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL dec_ctrl2_untouched got %h exp 0", d); end
        rd(32'h4022, d);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dec_misaligned_rd got %h exp ffffffff", d); end
        rd(32'h4040, d);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dec_above_rd got %h exp ffffffff", d); end
        rd(32'h401C, d);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dec_below_rd got %h exp ffffffff", d); end
        wr(32'h4028, 1);
        wr(32'h4020, 32'h003);
        step(2);
        n_vec++; if (irq !== 2'b10) begin n_err++; $display("FAIL dec_pend_before_rst got %b exp 10", irq); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL rst_mid_irq got %b exp 11", irq); end
        for (int i = 0; i < 4; i++) begin
            rd(32'h4020 + 32'(i * 4), d);
            n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_mid_reg%0d got %h exp 0", i, d); end
        end
        reset = 1'b1;
        step(3);
        rd(32'h4024, d);
        n_vec++; if (d !== 32'h0 || irq !== 2'b11) begin n_err++; $display("FAIL rst_after got count %h irq %b exp 0 11", d, irq); end
    endtask

    initial begin
        test_reset();
        test_autoreload();
        test_prescale();
        test_oneshot();
        test_collisions();
        test_decode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
